// File: rtl/cajero_multisesion_pkg.sv
// cajero_multisesion_pkg: shared state encodings and constants for the ATM controller.
// Rev 1.0
`default_nettype none

package cajero_multisesion_pkg;

  localparam logic [1:0] ST_ESPERANDO   = 2'd0;
  localparam logic [1:0] ST_INGRESO     = 2'd1;
  localparam logic [1:0] ST_TRANSACCION = 2'd2;
  localparam logic [1:0] ST_BLOQUEADO   = 2'd3;

  localparam int BP_DIV = 10000;

endpackage

`default_nettype wire

// File: rtl/cajero_pin_chk.sv
// cajero_pin_chk: serial PIN digit comparator with index counter and sticky mismatch flag.
// Rev 1.0
`default_nettype none

module cajero_pin_chk #(
  parameter int N_DIGITOS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   stb_i,
  input  logic [3:0]             digito_i,
  input  logic [4*N_DIGITOS-1:0] pin_i,
  output logic                   done_o,
  output logic                   ok_o
);

  localparam int IXW = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;

  logic [IXW-1:0] idx_q, idx_d;
  logic           mis_q, mis_d;
  logic [3:0]     w_dig [N_DIGITOS];
  logic           w_mis_now;

  // Most significant digit is entered first.
  for (genvar g = 0; g < N_DIGITOS; g++) begin : g_dig
    assign w_dig[g] = pin_i[4*(N_DIGITOS-1-g) +: 4];
  end

  assign w_mis_now = mis_q | (digito_i != w_dig[idx_q]);
  assign done_o    = stb_i && (idx_q == IXW'(N_DIGITOS-1));
  assign ok_o      = done_o && !w_mis_now;

  always_comb begin
    idx_d = idx_q;
    mis_d = mis_q;
    if (clr_i || done_o) begin
      idx_d = '0;
      mis_d = 1'b0;
    end else if (stb_i) begin
      idx_d = idx_q + IXW'(1);
      mis_d = w_mis_now;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= '0;
      mis_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      mis_q <= mis_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cajero_multisesion.sv
// cajero_multisesion: multi-transaction ATM session controller with PIN lockout and idle timeout.
// Rev 1.0
`default_nettype none

module cajero_multisesion
  import cajero_multisesion_pkg::*;
#(
  parameter int N_DIGITOS      = 4,
  parameter int MAX_INTENTOS   = 3,
  parameter int BW             = 64,
  parameter int MW             = 32,
  parameter int COMISION_BP    = 300,
  parameter int LIMITE_SESION  = 50000,
  parameter int TIMEOUT_CICLOS = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tarjeta_recibida,
  input  logic                   tipo_tarjeta,
  input  logic [4*N_DIGITOS-1:0] pin,
  input  logic [3:0]             digito,
  input  logic                   digito_stb,
  input  logic                   tipo_transaccion,
  input  logic [MW-1:0]          monto,
  input  logic                   monto_stb,
  input  logic                   carga_balance,
  input  logic [BW-1:0]          balance_in,
  output logic [BW-1:0]          balance_out,
  output logic                   balance_actualizado,
  output logic                   entregar_dinero,
  output logic                   fondos_insuficientes,
  output logic                   limite_excedido,
  output logic                   pin_incorrecto,
  output logic                   advertencia,
  output logic                   bloqueo,
  output logic                   timeout
);

  localparam int PW = MW + 14;
  localparam int EW = BW + 1;
  localparam int IW = $clog2(MAX_INTENTOS + 1);
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] balance_q, balance_d;
  logic [BW-1:0] sum_q, sum_d;
  logic [IW-1:0] intentos_q, intentos_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          retiro_q, retiro_d;
  logic          act_q, act_d, ent_q, ent_d, fon_q, fon_d, lim_q, lim_d;
  logic          pinc_q, pinc_d, adv_q, adv_d, blq_q, blq_d, to_q, to_d;

  logic          w_pin_done, w_pin_ok;
  logic [PW-1:0] w_prod;
  logic [EW-1:0] w_com, w_total, w_sum_tot, w_dep;
  logic [IW-1:0] w_int_inc;
  logic          w_idle_exp;

  cajero_pin_chk #(
    .N_DIGITOS (N_DIGITOS)
  ) u_pin_chk (
    .clk      (clk),
    .rst      (rst),
    .clr_i    ((state_q != ST_INGRESO) || !tarjeta_recibida),
    .stb_i    ((state_q == ST_INGRESO) && tarjeta_recibida && digito_stb),
    .digito_i (digito),
    .pin_i    (pin),
    .done_o   (w_pin_done),
    .ok_o     (w_pin_ok)
  );

  assign w_prod     = tipo_tarjeta ? (PW'(monto) * PW'(COMISION_BP)) : '0;
  assign w_com      = EW'(w_prod / PW'(BP_DIV));
  assign w_total    = EW'(monto) + w_com;
  assign w_sum_tot  = EW'(sum_q) + w_total;
  // Commission never exceeds monto, so the deposit cannot underflow.
  assign w_dep      = EW'(balance_q) + EW'(monto) - w_com;
  assign w_int_inc  = intentos_q + IW'(1);
  assign w_idle_exp = (timer_q == TW'(TIMEOUT_CICLOS - 1));

  always_comb begin
    state_d    = state_q;
    balance_d  = balance_q;
    sum_d      = sum_q;
    intentos_d = intentos_q;
    timer_d    = timer_q;
    retiro_d   = retiro_q;
    adv_d      = adv_q;
    blq_d      = blq_q;
    act_d      = 1'b0;
    ent_d      = 1'b0;
    fon_d      = 1'b0;
    lim_d      = 1'b0;
    pinc_d     = 1'b0;
    to_d       = 1'b0;
    case (state_q)
      ST_ESPERANDO: begin
        if (!tarjeta_recibida) retiro_d = 1'b0;
        if (carga_balance) balance_d = balance_in;
        // After a timeout the card has to leave the slot before a new session.
        if (tarjeta_recibida && !retiro_q) begin
          state_d = ST_INGRESO;
          sum_d   = '0;
          timer_d = '0;
        end
      end
      ST_INGRESO: begin
        if (!tarjeta_recibida) begin
          state_d = ST_ESPERANDO;
          adv_d   = 1'b0;
        end else if (digito_stb) begin
          timer_d = '0;
          if (w_pin_done) begin
            if (w_pin_ok) begin
              state_d    = ST_TRANSACCION;
              intentos_d = '0;
              adv_d      = 1'b0;
            end else begin
              pinc_d     = 1'b1;
              intentos_d = w_int_inc;
              if (w_int_inc == IW'(MAX_INTENTOS)) begin
                state_d = ST_BLOQUEADO;
                blq_d   = 1'b1;
                adv_d   = 1'b0;
              end else if (w_int_inc == IW'(MAX_INTENTOS - 1)) begin
                adv_d = 1'b1;
              end
            end
          end
        end else if (w_idle_exp) begin
          to_d     = 1'b1;
          state_d  = ST_ESPERANDO;
          retiro_d = 1'b1;
          adv_d    = 1'b0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_TRANSACCION: begin
        if (!tarjeta_recibida) begin
          state_d = ST_ESPERANDO;
        end else if (monto_stb) begin
          timer_d = '0;
          if (tipo_transaccion) begin
            if (w_sum_tot > EW'(LIMITE_SESION)) begin
              lim_d = 1'b1;
            end else if (w_total > EW'(balance_q)) begin
              fon_d = 1'b1;
            end else begin
              balance_d = balance_q - w_total[BW-1:0];
              sum_d     = w_sum_tot[BW-1:0];
              ent_d     = 1'b1;
              act_d     = 1'b1;
            end
          end else begin
            balance_d = w_dep[BW] ? {BW{1'b1}} : w_dep[BW-1:0];
            act_d     = 1'b1;
          end
        end else if (w_idle_exp) begin
          to_d     = 1'b1;
          state_d  = ST_ESPERANDO;
          retiro_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_BLOQUEADO: begin
        state_d = ST_BLOQUEADO;
      end
      default: state_d = ST_ESPERANDO;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_ESPERANDO;
      balance_q  <= '0;
      sum_q      <= '0;
      intentos_q <= '0;
      timer_q    <= '0;
      retiro_q   <= 1'b0;
      act_q      <= 1'b0;
      ent_q      <= 1'b0;
      fon_q      <= 1'b0;
      lim_q      <= 1'b0;
      pinc_q     <= 1'b0;
      adv_q      <= 1'b0;
      blq_q      <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      balance_q  <= balance_d;
      sum_q      <= sum_d;
      intentos_q <= intentos_d;
      timer_q    <= timer_d;
      retiro_q   <= retiro_d;
      act_q      <= act_d;
      ent_q      <= ent_d;
      fon_q      <= fon_d;
      lim_q      <= lim_d;
      pinc_q     <= pinc_d;
      adv_q      <= adv_d;
      blq_q      <= blq_d;
      to_q       <= to_d;
    end
  end

  assign balance_out          = balance_q;
  assign balance_actualizado  = act_q;
  assign entregar_dinero      = ent_q;
  assign fondos_insuficientes = fon_q;
  assign limite_excedido      = lim_q;
  assign pin_incorrecto       = pinc_q;
  assign advertencia          = adv_q;
  assign bloqueo              = blq_q;
  assign timeout              = to_q;

endmodule

`default_nettype wire

// File: tb/tb_cajero_multisesion.sv
// tb_cajero_multisesion: directed self-checking bench for cajero_multisesion.
// Rev 1.0
`default_nettype none

module tb_cajero_multisesion;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tarjeta_recibida = 1'b0;
  logic        tipo_tarjeta = 1'b0;
  logic [15:0] pin = 16'h1234;
  logic [3:0]  digito = '0;
  logic        digito_stb = 1'b0;
  logic        tipo_transaccion = 1'b0;
  logic [31:0] monto = '0;
  logic        monto_stb = 1'b0;
  logic        carga_balance = 1'b0;
  logic [63:0] balance_in = '0;
  logic [63:0] balance_out;
  logic        balance_actualizado, entregar_dinero, fondos_insuficientes;
  logic        limite_excedido, pin_incorrecto, advertencia, bloqueo, timeout;

  int n_checks = 0;
  int n_fail   = 0;

  cajero_multisesion #(
    .N_DIGITOS      (4),
    .MAX_INTENTOS   (3),
    .BW             (64),
    .MW             (32),
    .COMISION_BP    (300),
    .LIMITE_SESION  (150),
    .TIMEOUT_CICLOS (TO)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .tarjeta_recibida     (tarjeta_recibida),
    .tipo_tarjeta         (tipo_tarjeta),
    .pin                  (pin),
    .digito               (digito),
    .digito_stb           (digito_stb),
    .tipo_transaccion     (tipo_transaccion),
    .monto                (monto),
    .monto_stb            (monto_stb),
    .carga_balance        (carga_balance),
    .balance_in           (balance_in),
    .balance_out          (balance_out),
    .balance_actualizado  (balance_actualizado),
    .entregar_dinero      (entregar_dinero),
    .fondos_insuficientes (fondos_insuficientes),
    .limite_excedido      (limite_excedido),
    .pin_incorrecto       (pin_incorrecto),
    .advertencia          (advertencia),
    .bloqueo              (bloqueo),
    .timeout              (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_bal(input logic [63:0] v);
    @(negedge clk);
    carga_balance = 1'b1;
    balance_in    = v;
    tick();
    carga_balance = 1'b0;
  endtask

  task automatic card(input logic present, input logic foreign);
    @(negedge clk);
    tarjeta_recibida = present;
    tipo_tarjeta     = foreign;
    tick();
  endtask

  task automatic digit(input logic [3:0] d);
    @(negedge clk);
    digito     = d;
    digito_stb = 1'b1;
    tick();
    digito_stb = 1'b0;
  endtask

  task automatic enter_pin(input logic [15:0] p);
    for (int i = 0; i < 4; i++) digit(p[15-4*i -: 4]);
  endtask

  task automatic txn(input logic withdraw, input logic [31:0] m);
    @(negedge clk);
    tipo_transaccion = withdraw;
    monto            = m;
    monto_stb        = 1'b1;
    tick();
    monto_stb = 1'b0;
  endtask

  initial begin
    int n;
    // Reset state
    #2;
    chk("rst_balance", balance_out, 64'd0);
    chk("rst_outputs", {56'd0, balance_actualizado, entregar_dinero, fondos_insuficientes,
        limite_excedido, pin_incorrecto, advertencia, bloqueo, timeout}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Local card: load, PIN, several withdrawals, limit, deposit
    load_bal(64'd1000);
    chk("load_1000", balance_out, 64'd1000);
    card(1'b1, 1'b0);
    enter_pin(16'h1234);
    chk("pin_ok_no_err", pin_incorrecto, 1'b0);
    txn(1'b1, 32'd100);
    chk("wd100_entregar", entregar_dinero, 1'b1);
    chk("wd100_act", balance_actualizado, 1'b1);
    chk("wd100_bal", balance_out, 64'd900);
    tick();
    chk("entregar_pulse_end", entregar_dinero, 1'b0);
    txn(1'b1, 32'd30);
    chk("wd30_bal", balance_out, 64'd870);
    txn(1'b1, 32'd30);
    chk("limit_pulse", limite_excedido, 1'b1);
    chk("limit_no_entregar", entregar_dinero, 1'b0);
    chk("limit_bal", balance_out, 64'd870);
    txn(1'b0, 32'd500);
    chk("dep500_act", balance_actualizado, 1'b1);
    chk("dep500_bal", balance_out, 64'd1370);
    card(1'b0, 1'b0);

    // Fresh session: limit counter restarts
    load_bal(64'd1000);
    card(1'b1, 1'b0);
    enter_pin(16'h1234);
    txn(1'b1, 32'd100);
    chk("s2_wd100_bal", balance_out, 64'd900);
    txn(1'b1, 32'd60);
    chk("s2_wd60_limit", limite_excedido, 1'b1);
    chk("s2_wd60_bal", balance_out, 64'd900);
    card(1'b0, 1'b0);

    // Foreign card commission
    load_bal(64'd1000);
    card(1'b1, 1'b1);
    enter_pin(16'h1234);
    txn(1'b1, 32'd100);
    chk("fx_wd100_bal", balance_out, 64'd897);
    txn(1'b0, 32'd200);
    chk("fx_dep200_bal", balance_out, 64'd1091);
    txn(1'b1, 32'd33);
    chk("fx_wd33_trunc", balance_out, 64'd1058);
    card(1'b0, 1'b0);

    // Insufficient funds, limit priority, removal beats strobe
    load_bal(64'd50);
    card(1'b1, 1'b0);
    enter_pin(16'h1234);
    txn(1'b1, 32'd100);
    chk("fondos_pulse", fondos_insuficientes, 1'b1);
    chk("fondos_no_limit", limite_excedido, 1'b0);
    chk("fondos_bal", balance_out, 64'd50);
    txn(1'b1, 32'd200);
    chk("prio_limit", limite_excedido, 1'b1);
    chk("prio_no_fondos", fondos_insuficientes, 1'b0);
    @(negedge clk);
    tarjeta_recibida = 1'b0;
    tipo_transaccion = 1'b1;
    monto            = 32'd10;
    monto_stb        = 1'b1;
    tick();
    monto_stb = 1'b0;
    chk("remove_same_cycle_ent", entregar_dinero, 1'b0);
    chk("remove_same_cycle_bal", balance_out, 64'd50);
    card(1'b1, 1'b0);
    txn(1'b1, 32'd10);
    chk("monto_in_ingreso_ign", entregar_dinero, 1'b0);
    chk("monto_in_ingreso_bal", balance_out, 64'd50);
    card(1'b0, 1'b0);

    // Deposit saturation
    load_bal(64'hFFFF_FFFF_FFFF_FFF6);
    card(1'b1, 1'b0);
    enter_pin(16'h1234);
    txn(1'b0, 32'd100);
    chk("dep_saturate", balance_out, 64'hFFFF_FFFF_FFFF_FFFF);
    card(1'b0, 1'b0);

    // Idle timeout in TRANSACCION
    load_bal(64'd1000);
    card(1'b1, 1'b0);
    enter_pin(16'h1234);
    n = 0;
    while (!timeout && n < 3 * TO) begin
      tick();
      n++;
    end
    chk("timeout_seen", timeout, 1'b1);
    chk("timeout_cycles", 64'(n), 64'(TO));
    tick();
    chk("timeout_pulse_end", timeout, 1'b0);
    enter_pin(16'h1234);
    txn(1'b1, 32'd100);
    chk("after_to_no_txn", entregar_dinero, 1'b0);
    chk("after_to_bal", balance_out, 64'd1000);
    card(1'b0, 1'b0);
    card(1'b1, 1'b0);
    enter_pin(16'h1234);
    txn(1'b1, 32'd100);
    chk("reinsert_wd_bal", balance_out, 64'd900);
    card(1'b0, 1'b0);

    // Wrong PINs, counter persists across removal, lockout
    card(1'b1, 1'b0);
    enter_pin(16'h1235);
    chk("wrong1_pulse", pin_incorrecto, 1'b1);
    chk("wrong1_adv", advertencia, 1'b0);
    card(1'b0, 1'b0);
    card(1'b1, 1'b0);
    enter_pin(16'h1235);
    chk("wrong2_pulse", pin_incorrecto, 1'b1);
    chk("wrong2_adv", advertencia, 1'b1);
    enter_pin(16'h0000);
    chk("wrong3_pulse", pin_incorrecto, 1'b1);
    chk("wrong3_bloqueo", bloqueo, 1'b1);
    tick();
    chk("wrong3_pulse_end", pin_incorrecto, 1'b0);
    enter_pin(16'h1234);
    txn(1'b1, 32'd100);
    chk("locked_no_txn", entregar_dinero, 1'b0);
    chk("locked_bal", balance_out, 64'd900);
    card(1'b0, 1'b0);
    chk("locked_sticky", bloqueo, 1'b1);

    // Async reset clears lockout and balance
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("rst2_bloqueo", bloqueo, 1'b0);
    chk("rst2_balance", balance_out, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
